aes_core_sequencer: RTL and testbench

Front-end controller for one Encrypt core and one Decrypt core, both using the serial cs/miso/mosi/finished interface. Accepts a 128-bit block, a 128-bit key and a mode from a parallel valid/ready requester. Serialises data then key into the selected core, waits for the core to finish, then shifts the 128-bit result back and presents it on a valid/ready response port. Only one operation is in flight at a time; the unused core's cs is held low.

---
 rtl/aes_seq_pkg.sv | 22 ++
 rtl/aes_serial_shifter.sv | 48 ++++
 rtl/aes_core_sequencer.sv | 175 +++++++++++++++++
 tb/tb_aes_core_sequencer.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES core sequencer.
// Load layout is {key, data}, shifted out LSB first.
package aes_seq_pkg;

  localparam int BLOCK_BITS = 128;
  localparam int LOAD_BITS  = 256;
  localparam int CNT_W      = 9;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_IN,
    PROCESS,
    READ_SETUP,
    SHIFT_OUT,
    RESP
  } state_t;

endpackage

// File: rtl/aes_serial_shifter.sv
// 256-bit PISO/SIPO shift register with a 9-bit bit counter.
// Shifts right; serial input enters at the MSB.
module aes_serial_shifter
  import aes_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [LOAD_BITS-1:0]  load_val,
  input  logic                  shift,
  input  logic                  sin,
  input  logic                  clr,
  input  logic                  count,
  input  logic [CNT_W-1:0]      last,
  output logic                  lsb,
  output logic [BLOCK_BITS-1:0] capture,
  output logic                  tc
);

  logic [LOAD_BITS-1:0] q;
  logic [CNT_W-1:0]     cnt;

  // Shift register: parallel load or shift right.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {sin, q[LOAD_BITS-1:1]};
    end
  end

  // Bit counter: reloads to 0 on each state entry.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign lsb     = q[0];
  // Upper half as it will be after the pending shift.
  assign capture = {sin, q[LOAD_BITS-1:BLOCK_BITS+1]};
  assign tc      = (cnt == last);

endmodule

// File: rtl/aes_core_sequencer.sv
// Serial front end for one Encrypt and one Decrypt core.
// Loads {key,data} serially, waits, then reads the result.
module aes_core_sequencer
  import aes_seq_pkg::*;
#(
  parameter int LOAD_GAP = 1,
  parameter int TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_mode,
  input  logic [BLOCK_BITS-1:0] req_data,
  input  logic [BLOCK_BITS-1:0] req_key,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BLOCK_BITS-1:0] rsp_data,
  output logic                  rsp_mode,
  output logic                  rsp_err,
  output logic                  cs_enc,
  output logic                  miso_enc,
  input  logic                  mosi_enc,
  input  logic                  finished_enc,
  output logic                  cs_dec,
  output logic                  miso_dec,
  input  logic                  mosi_dec,
  input  logic                  finished_dec
);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(LOAD_GAP - 1);
  localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(LOAD_BITS - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(BLOCK_BITS - 1);
  localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT - 1);

  state_t state;
  logic   mode;
  logic [7:0] tcnt;

  logic is_enc, fin, sin, go, to_hit;
  logic load, shift, count, leave, lsb, tc;
  logic [CNT_W-1:0]      last;
  logic [BLOCK_BITS-1:0] capture;

  // Core muxing and shifter control for the current state.
  always_comb begin
    is_enc = (mode == MODE_ENC);
    fin    = is_enc ? finished_enc : finished_dec;
    sin    = is_enc ? mosi_enc : mosi_dec;
    go     = req_valid & req_ready;
    to_hit = (tcnt == TO_LAST);
    load   = (state == IDLE) & go;
    count  = (state == SETUP) | (state == SHIFT_IN) |
             (state == READ_SETUP) | (state == SHIFT_OUT);
    shift  = ((state == SETUP) & tc) |
             ((state == SHIFT_IN) & !tc) |
             (state == SHIFT_OUT);
    last   = GAP_LAST;
    unique case (1'b1)
      (state == SHIFT_IN):  last = IN_LAST;
      (state == SHIFT_OUT): last = OUT_LAST;
      default:              last = GAP_LAST;
    endcase
    leave = 1'b0;
    case (state)
      IDLE:       leave = go;
      PROCESS:    leave = fin | to_hit;
      RESP:       leave = rsp_ready;
      default:    leave = tc;
    endcase
  end

  aes_serial_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val ({req_key, req_data}),
    .shift    (shift),
    .sin      (sin),
    .clr      (leave),
    .count    (count),
    .last     (last),
    .lsb      (lsb),
    .capture  (capture),
    .tc       (tc)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode      <= MODE_ENC;
      tcnt      <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_mode  <= 1'b0;
      rsp_err   <= 1'b0;
      cs_enc    <= 1'b0;
      cs_dec    <= 1'b0;
      miso_enc  <= 1'b0;
      miso_dec  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= !go;
          if (go) begin
            state  <= SETUP;
            mode   <= req_mode;
            cs_enc <= (req_mode == MODE_ENC);
            cs_dec <= (req_mode == MODE_DEC);
          end
        end
        SETUP: begin
          if (tc) begin
            state    <= SHIFT_IN;
            miso_enc <= is_enc & lsb;
            miso_dec <= !is_enc & lsb;
          end
        end
        SHIFT_IN: begin
          if (tc) begin
            state    <= PROCESS;
            tcnt     <= '0;
            cs_enc   <= 1'b0;
            cs_dec   <= 1'b0;
            miso_enc <= 1'b0;
            miso_dec <= 1'b0;
          end else begin
            miso_enc <= is_enc & lsb;
            miso_dec <= !is_enc & lsb;
          end
        end
        PROCESS: begin
          tcnt <= tcnt + 8'd1;
          if (fin) begin
            state  <= READ_SETUP;
            cs_enc <= is_enc;
            cs_dec <= !is_enc;
          end else if (to_hit) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_mode  <= mode;
          end
        end
        READ_SETUP: begin
          if (tc) state <= SHIFT_OUT;
        end
        SHIFT_OUT: begin
          if (tc) begin
            state     <= RESP;
            cs_enc    <= 1'b0;
            cs_dec    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= capture;
            rsp_mode  <= mode;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_sequencer.sv
// Self-checking bench for aes_core_sequencer.
// A mock core captures the serial load and returns a chosen result.
module tb_aes_core_sequencer;

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_mode = 1'b0;
  logic rsp_ready = 1'b0;
  logic mosi_enc = 1'b0;
  logic finished_enc = 1'b0;
  logic mosi_dec = 1'b0;
  logic finished_dec = 1'b0;
  logic [127:0] req_data = '0;
  logic [127:0] req_key = '0;
  logic req_ready, rsp_valid, rsp_mode, rsp_err;
  logic cs_enc, miso_enc, cs_dec, miso_dec;
  logic [127:0] rsp_data;

  int n_checks = 0;
  int n_fail = 0;
  int enc_hi = 0;
  int dec_hi = 0;

  aes_core_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mode     (req_mode),
    .req_data     (req_data),
    .req_key      (req_key),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_mode     (rsp_mode),
    .rsp_err      (rsp_err),
    .cs_enc       (cs_enc),
    .miso_enc     (miso_enc),
    .mosi_enc     (mosi_enc),
    .finished_enc (finished_enc),
    .cs_dec       (cs_dec),
    .miso_dec     (miso_dec),
    .mosi_dec     (mosi_dec),
    .finished_dec (finished_dec)
  );

  always #5 clk = ~clk;

  // Activity seen on each core interface.
  always @(negedge clk) begin
    if (cs_enc || miso_enc) enc_hi <= enc_hi + 1;
    if (cs_dec || miso_dec) dec_hi <= dec_hi + 1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [135:0] outs();
    return {req_ready, rsp_valid, rsp_mode, rsp_err,
            cs_enc, miso_enc, cs_dec, miso_dec, rsp_data};
  endfunction

  function automatic logic cs_of(input logic m);
    return m ? cs_dec : cs_enc;
  endfunction

  function automatic logic miso_of(input logic m);
    return m ? miso_dec : miso_enc;
  endfunction

  task automatic set_fin(input logic m, input logic v);
    if (m) finished_dec = v;
    else   finished_enc = v;
  endtask

  task automatic set_mosi(input logic m, input logic v);
    if (m) mosi_dec = v;
    else   mosi_enc = v;
  endtask

  // Drive one request and play the selected core; stop in RESP.
  task automatic run_op(
    input  logic         m,
    input  logic [127:0] d,
    input  logic [127:0] k,
    input  logic [127:0] r,
    input  int           delay,
    input  bit           fin_en,
    output logic [255:0] cap,
    output int           pcyc,
    output int           cs_bad,
    output bit           hung
  );
    int n;
    cap = '0;
    pcyc = 0;
    cs_bad = 0;
    hung = 1'b0;
    finished_enc = m;
    finished_dec = !m;
    mosi_enc = m;
    mosi_dec = !m;
    req_mode = m;
    req_data = d;
    req_key = k;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      hung = 1'b1;
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (cs_of(m) !== 1'b1) cs_bad++;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      cap[i] = miso_of(m);
      if (cs_of(m) !== 1'b1) cs_bad++;
    end
    @(negedge clk);
    if (cs_of(m) !== 1'b0) cs_bad++;
    if (!fin_en) begin
      n = 0;
      while (!rsp_valid && n < 300) begin
        @(negedge clk);
        n++;
        if (cs_of(m) !== 1'b0) cs_bad++;
      end
      pcyc = n;
      if (!rsp_valid) hung = 1'b1;
      return;
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (cs_of(m) !== 1'b0 || rsp_valid) cs_bad++;
    end
    pcyc = delay + 1;
    set_fin(m, 1'b1);
    @(negedge clk);
    set_fin(m, 1'b0);
    if (cs_of(m) !== 1'b1) cs_bad++;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (cs_of(m) !== 1'b1) cs_bad++;
      set_mosi(m, r[i]);
    end
    @(negedge clk);
    set_mosi(m, 1'b0);
    if (cs_of(m) !== 1'b0) cs_bad++;
    if (!rsp_valid) hung = 1'b1;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (outs() !== 136'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h want 0", outs());
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_encrypt();
    logic [255:0] cap;
    int pc, bad, d0;
    bit hung;
    d0 = dec_hi;
    run_op(1'b0, PT1, K1, CT1, 10, 1'b1, cap, pc, bad, hung);
    n_checks++;
    if (hung || bad != 0) begin
      n_fail++;
      $display("FAIL enc_proto: hung %0d cs_errs %0d want 0 0", hung, bad);
    end
    n_checks++;
    if (cap !== {K1, PT1}) begin
      n_fail++;
      $display("FAIL enc_load: got %h want %h", cap, {K1, PT1});
    end
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_mode, rsp_data} !== {3'b100, CT1}) begin
      n_fail++;
      $display("FAIL enc_rsp: got %b%b%b %h want 100 %h",
               rsp_valid, rsp_err, rsp_mode, rsp_data, CT1);
    end
    n_checks++;
    if (dec_hi != d0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL enc_isolation: dec activity %0d ready %b want 0 0",
               dec_hi - d0, req_ready);
    end
    handshake();
    n_checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL enc_release: valid/ready %b%b want 01",
               rsp_valid, req_ready);
    end
  endtask

  task automatic test_decrypt();
    logic [255:0] cap;
    int pc, bad, e0;
    bit hung;
    e0 = enc_hi;
    run_op(1'b1, CT2, K2, PT2, 25, 1'b1, cap, pc, bad, hung);
    n_checks++;
    if (hung || bad != 0 || cap !== {K2, CT2}) begin
      n_fail++;
      $display("FAIL dec_load: hung %0d cs_errs %0d load %h want %h",
               hung, bad, cap, {K2, CT2});
    end
    n_checks++;
    if ({rsp_err, rsp_mode, rsp_data} !== {2'b01, PT2}) begin
      n_fail++;
      $display("FAIL dec_rsp: got %b%b %h want 01 %h",
               rsp_err, rsp_mode, rsp_data, PT2);
    end
    n_checks++;
    if (enc_hi != e0) begin
      n_fail++;
      $display("FAIL dec_isolation: enc activity %0d want 0", enc_hi - e0);
    end
    handshake();
  endtask

  task automatic test_timeout();
    logic [255:0] cap;
    logic [127:0] d, k, r;
    int pc, bad;
    bit hung;
    d = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    run_op(1'b0, d, k, 128'd0, 0, 1'b0, cap, pc, bad, hung);
    n_checks++;
    if (hung || pc != TMO || bad != 0) begin
      n_fail++;
      $display("FAIL tmo_cycles: got %0d (hung %0d cs_errs %0d) want %0d",
               pc, hung, bad, TMO);
    end
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 128'd0}) begin
      n_fail++;
      $display("FAIL tmo_rsp: got %b%b %h want 11 0",
               rsp_valid, rsp_err, rsp_data);
    end
    handshake();
    n_checks++;
    if (rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_err_clear: got %b want 0", rsp_err);
    end
    r = {$urandom, $urandom, $urandom, $urandom};
    run_op(1'b0, d, k, r, 5, 1'b1, cap, pc, bad, hung);
    n_checks++;
    if (hung || {rsp_err, rsp_data} !== {1'b0, r}) begin
      n_fail++;
      $display("FAIL tmo_recover: got %b %h want 0 %h", rsp_err, rsp_data, r);
    end
    handshake();
  endtask

  task automatic test_finish_boundary();
    logic [255:0] cap;
    logic [127:0] r;
    int pc, bad;
    bit hung;
    r = {$urandom, $urandom, $urandom, $urandom};
    run_op(1'b1, PT1, K1, r, TMO - 1, 1'b1, cap, pc, bad, hung);
    n_checks++;
    if (hung || bad != 0 || {rsp_err, rsp_data} !== {1'b0, r}) begin
      n_fail++;
      $display("FAIL fin_wins: err %b data %h cs_errs %0d want 0 %h 0",
               rsp_err, rsp_data, bad, r);
    end
    handshake();
    run_op(1'b0, PT2, K2, ~r, 0, 1'b1, cap, pc, bad, hung);
    n_checks++;
    if (hung || bad != 0 || {rsp_err, rsp_data} !== {1'b0, ~r}) begin
      n_fail++;
      $display("FAIL fin_immediate: err %b data %h want 0 %h",
               rsp_err, rsp_data, ~r);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    logic [255:0] cap;
    logic [135:0] snap;
    logic [127:0] d2, k2, r2;
    int pc, bad, unstable;
    bit hung;
    run_op(1'b0, PT1, K1, CT1, 3, 1'b1, cap, pc, bad, hung);
    snap = outs();
    d2 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    r2 = {$urandom, $urandom, $urandom, $urandom};
    req_mode = 1'b1;
    req_data = d2;
    req_key = k2;
    req_valid = 1'b1;
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (outs() !== snap || !rsp_valid || req_ready) unstable++;
    end
    n_checks++;
    if (hung || unstable != 0 || snap[127:0] !== CT1) begin
      n_fail++;
      $display("FAIL bp_hold: unstable cycles %0d data %h want 0 %h",
               unstable, snap[127:0], CT1);
    end
    handshake();
    n_checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_accept: valid/ready %b%b want 01",
               rsp_valid, req_ready);
    end
    run_op(1'b1, d2, k2, r2, 7, 1'b1, cap, pc, bad, hung);
    n_checks++;
    if (hung || cap !== {k2, d2} || rsp_data !== r2) begin
      n_fail++;
      $display("FAIL bp_second: load %h data %h want %h %h",
               cap, rsp_data, {k2, d2}, r2);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    logic [255:0] cap;
    int pc, bad, n;
    bit hung;
    logic exp_bit;
    req_mode = 1'b0;
    req_data = PT1;
    req_key = K1;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (101) @(negedge clk);
    exp_bit = PT1[100];
    n_checks++;
    if ({cs_enc, miso_enc} !== {1'b1, exp_bit}) begin
      n_fail++;
      $display("FAIL mid_bit100: cs/miso %b%b want 1%b",
               cs_enc, miso_enc, exp_bit);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs() !== 136'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got %h want 0", outs());
    end
    rst = 1'b0;
    run_op(1'b0, PT1, K1, CT1, 12, 1'b1, cap, pc, bad, hung);
    n_checks++;
    if (hung || bad != 0 || cap !== {K1, PT1} || rsp_data !== CT1) begin
      n_fail++;
      $display("FAIL mid_recover: data %h want %h", rsp_data, CT1);
    end
    handshake();
  endtask

  task automatic test_bit_order();
    logic [255:0] cap;
    logic [127:0] d, k, r;
    int pc, bad, ones;
    bit hung;
    d = 128'd1;
    k = 128'd1 << 127;
    r = 128'd1 << 127;
    run_op(1'b0, d, k, r, 2, 1'b1, cap, pc, bad, hung);
    ones = $countones(cap);
    n_checks++;
    if (hung || ones != 2 || cap[0] !== 1'b1 || cap[255] !== 1'b1) begin
      n_fail++;
      $display("FAIL order_in: got %h want bits 0 and 255 only", cap);
    end
    n_checks++;
    if (rsp_data !== 128'h80000000000000000000000000000000) begin
      n_fail++;
      $display("FAIL order_out: got %h want 800..0", rsp_data);
    end
    handshake();
  endtask

  task automatic test_random();
    logic [255:0] cap;
    logic [127:0] d, k, r, exp_data;
    logic m, exp_err;
    int pc, bad, dly, hold;
    bit hung, fe;
    for (int it = 0; it < 8; it++) begin
      m = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      r = {$urandom, $urandom, $urandom, $urandom};
      dly = $urandom_range(0, TMO - 1);
      fe = ($urandom_range(0, 4) != 0);
      exp_err = !fe;
      exp_data = fe ? r : 128'd0;
      run_op(m, d, k, r, dly, fe, cap, pc, bad, hung);
      n_checks++;
      if (hung || bad != 0 || cap !== {k, d} ||
          {rsp_valid, rsp_err, rsp_mode, rsp_data} !==
          {1'b1, exp_err, m, exp_data}) begin
        n_fail++;
        $display("FAIL rand_%0d: err %b mode %b data %h want %b %b %h",
                 it, rsp_err, rsp_mode, rsp_data, exp_err, m, exp_data);
      end
      hold = $urandom_range(0, 3);
      repeat (hold) @(negedge clk);
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_timeout();
    test_finish_boundary();
    test_backpressure();
    test_reset_mid();
    test_bit_order();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
